piso_shift_tx: RTL and testbench

- Parallel-in, serial-out shift register transmitter; the sending end of the serial-in, parallel-out shift register link.
- Accepts a WIDTH-bit word through a valid/ready load handshake and drives it out one bit per accepted tick on `sout`, with `sout_valid` framing each bit.
- Sits between a parallel data source and the serial input `x` of the receiving shift register.
- A `tick` enable lets the serial rate be a divided-down fraction of `clk`.

---
 rtl/piso_shift_tx.sv | 97 +++++++++
 tb/tb_piso_shift_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in, serial-out transmitter with a valid/ready load
// handshake and a tick enable for the serial bit rate.
//
// A word is captured on the accept edge. Its first bit is on `sout` during the
// next cycle. The word then advances one bit on each edge where tick=1. The
// shift register always keeps the current bit at its output end, so `sout` is
// a plain register bit. Vacated positions fill with zero, which means `sout`
// reads 0 whenever the block is idle.
module piso_shift_tx #(
  parameter int WIDTH     = 4,     // bits per word, must be >= 2
  parameter bit MSB_FIRST = 1'b1   // 1: din[WIDTH-1] goes first, 0: din[0] goes first
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active low
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             tick,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic             r_done;
  logic             w_last;
  logic             w_accept;

  // The last bit retires on this edge. A new word may be accepted on the same
  // edge, so the next word follows with no gap.
  assign w_last     = (r_state == S_SHIFT) && (r_bit_cnt == LAST_CNT) && tick;
  assign load_ready = (r_state == S_IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;

  // The shift register moves toward the output end. The far end refills with zero.
  assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shift[WIDTH-1:1]};

  // The outputs come directly from registers. sout_valid and busy both mean
  // that the block is in the SHIFT state.
  assign sout       = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign sout_valid = (r_state == S_SHIFT);
  assign busy       = (r_state == S_SHIFT);
  assign done       = r_done;

  // Next-state logic: accept a new word, retire the last bit, or advance one bit.
  always_comb begin
    // NOTE: every signal gets a hold-value default before any branch, so no path leaves one unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    if (w_accept) begin
      w_state_nxt   = S_SHIFT;
      w_shift_nxt   = din;
      w_bit_cnt_nxt = '0;
    end else if (w_last) begin
      w_state_nxt   = S_IDLE;
      w_shift_nxt   = '0;
      w_bit_cnt_nxt = '0;
    end else if ((r_state == S_SHIFT) && tick) begin
      w_shift_nxt   = w_shifted;
      w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
    end
  end

  // State registers. An asynchronous clear drops any word that is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples pre-edge values regardless of statement order.
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_done    <= w_last;
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Testbench for piso_shift_tx. Two instances are tested: an MSB-first one and
// an LSB-first one. Directed stimulus pushes the expected serial bits into a
// queue for each instance. A monitor for each instance pops one bit on every
// cycle where sout_valid=1 and compares it. Directed checks cover the
// handshake, done, busy and reset timing.
module tb_piso_shift_tx;

  logic       clk;
  logic       reset;

  // Instance A: MSB first.
  logic [3:0] din_a;
  logic       load_valid_a, load_ready_a, tick_a;
  logic       sout_a, sout_valid_a, busy_a, done_a;

  // Instance B: LSB first.
  logic [3:0] din_b;
  logic       load_valid_b, load_ready_b, tick_b;
  logic       sout_b, sout_valid_b, busy_b, done_b;

  // Loopback receiver model: a 4-bit serial-in register that shifts left.
  logic [3:0] rx_out;

  int total = 0;
  int bad   = 0;

  bit q_a[$];
  bit q_b[$];

  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .din        (din_a),
    .load_valid (load_valid_a),
    .load_ready (load_ready_a),
    .tick       (tick_a),
    .sout       (sout_a),
    .sout_valid (sout_valid_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .din        (din_b),
    .load_valid (load_valid_b),
    .load_ready (load_ready_b),
    .tick       (tick_b),
    .sout       (sout_b),
    .sout_valid (sout_valid_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The receiver shifts in sout only when sout_valid marks it.
  always @(posedge clk) begin
    if (sout_valid_a) rx_out <= {rx_out[2:0], sout_a};
  end

  // Scoreboard monitors. Each one pops one expected bit per valid cycle.
  always @(negedge clk) begin
    if (reset && sout_valid_a) begin
      if (q_a.size() == 0) check("a_unexpected_bit", 32'(sout_a), 32'h2);
      else                 check("a_sout", 32'(sout_a), 32'(q_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (reset && sout_valid_b) begin
      if (q_b.size() == 0) check("b_unexpected_bit", 32'(sout_b), 32'h2);
      else                 check("b_sout", 32'(sout_b), 32'(q_b.pop_front()));
    end
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [3:0] bits_msb_first);
    for (int i = 3; i >= 0; i--) q_a.push_back(bits_msb_first[i]);
  endtask

  initial begin
    reset = 1'b0;
    din_a = '0; load_valid_a = 1'b0; tick_a = 1'b1;
    din_b = '0; load_valid_b = 1'b0; tick_b = 1'b1;
    rx_out = '0;

    // Reset state.
    #2;
    check("rst_sout",       32'(sout_a),       32'h0);
    check("rst_sout_valid", 32'(sout_valid_a), 32'h0);
    check("rst_busy",       32'(busy_a),       32'h0);
    check("rst_done",       32'(done_a),       32'h0);
    check("rst_load_ready", 32'(load_ready_a), 32'h1);
    step();
    reset = 1'b1;
    step();
    step();
    check("idle_tick_no_effect", 32'(sout_valid_a), 32'h0);

    // Single word 1011, tick tied high.
    rx_out = '0;
    din_a = 4'b1011; load_valid_a = 1'b1;
    push_a(4'b1011);
    step();                       // accept edge N, now in cycle N+1
    load_valid_a = 1'b0;
    check("t1_busy",        32'(busy_a),       32'h1);
    check("t1_sout_valid",  32'(sout_valid_a), 32'h1);
    check("t1_ready_mid",   32'(load_ready_a), 32'h0);
    step(); step(); step();       // cycle N+4, last bit
    check("t1_ready_last",  32'(load_ready_a), 32'h1);
    check("t1_done_early",  32'(done_a),       32'h0);
    step();                       // cycle N+5
    check("t1_done",        32'(done_a),       32'h1);
    check("t1_valid_off",   32'(sout_valid_a), 32'h0);
    check("t1_busy_off",    32'(busy_a),       32'h0);
    check("t1_sout_zero",   32'(sout_a),       32'h0);
    check("t1_ready_idle",  32'(load_ready_a), 32'h1);
    check("t1_loopback",    32'(rx_out),       32'hB);
    step();
    check("t1_done_pulse",  32'(done_a),       32'h0);

    // Back to back: 1011, then 0110.
    din_a = 4'b1011; load_valid_a = 1'b1;
    push_a(4'b1011);
    push_a(4'b0110);
    step();                       // accept edge N for word 1
    din_a = 4'b0110;              // the source presents word 2 and holds it
    for (int i = 0; i < 3; i++) begin
      check("t2_valid_w1", 32'(sout_valid_a), 32'h1);
      check("t2_done_w1",  32'(done_a),       32'h0);
      step();
    end
    check("t2_ready_last", 32'(load_ready_a), 32'h1);
    step();                       // word 2 is accepted on the last-bit edge
    load_valid_a = 1'b0;
    check("t2_done_overlap", 32'(done_a),       32'h1);
    check("t2_valid_gap",    32'(sout_valid_a), 32'h1);
    check("t2_w2_first",     32'(sout_a),       32'h0);
    step();
    check("t2_done_once",    32'(done_a),       32'h0);
    step(); step();
    check("t2_valid_w2",     32'(sout_valid_a), 32'h1);
    step();
    check("t2_done_end",     32'(done_a),       32'h1);
    check("t2_valid_end",    32'(sout_valid_a), 32'h0);

    // Tick high one cycle in three, din 1100: each bit is held for 3 cycles.
    step();
    din_a = 4'b1100; load_valid_a = 1'b1; tick_a = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      bit b;
      b = (i >= 2);
      repeat (3) q_a.push_back(b);
    end
    step();                       // accept without tick
    load_valid_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick_a = (k % 3 == 0);
      if (k == 12) check("t3_done_before", 32'(done_a), 32'h0);
      step();
    end
    tick_a = 1'b1;
    check("t3_done",      32'(done_a),       32'h1);
    check("t3_valid_off", 32'(sout_valid_a), 32'h0);

    // LSB first, din 0001. A mid-word load of 1111 must be ignored.
    din_b = 4'b0001; load_valid_b = 1'b1;
    q_b.push_back(1'b1); q_b.push_back(1'b0); q_b.push_back(1'b0); q_b.push_back(1'b0);
    step();
    load_valid_b = 1'b0;
    step();                       // cycle N+2
    din_b = 4'b1111; load_valid_b = 1'b1;
    check("t4_ready_busy", 32'(load_ready_b), 32'h0);
    step();                       // cycle N+3, load still refused
    check("t4_ready_busy2", 32'(load_ready_b), 32'h0);
    load_valid_b = 1'b0;
    step(); step();               // cycle N+5
    check("t4_done",      32'(done_b),       32'h1);
    check("t4_idle",      32'(sout_valid_b), 32'h0);

    // Asynchronous reset after 2 bits, then word 1010 is sent intact.
    din_a = 4'b1011; load_valid_a = 1'b1;
    q_a.push_back(1'b1); q_a.push_back(1'b0);
    step();
    load_valid_a = 1'b0;
    step();                       // second bit on sout
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;                           // no clock edge since reset went low
    check("t5_sout",       32'(sout_a),       32'h0);
    check("t5_sout_valid", 32'(sout_valid_a), 32'h0);
    check("t5_busy",       32'(busy_a),       32'h0);
    check("t5_done",       32'(done_a),       32'h0);
    step();
    reset = 1'b1;
    step();
    check("t5_ready",      32'(load_ready_a), 32'h1);
    check("t5_no_done",    32'(done_a),       32'h0);
    check("t5_q_drained",  32'(q_a.size()),   32'h0);
    din_a = 4'b1010; load_valid_a = 1'b1;
    push_a(4'b1010);
    step();
    load_valid_a = 1'b0;
    step(); step(); step(); step();
    check("t5_done_after", 32'(done_a),       32'h1);

    step();
    check("final_q_a_empty", 32'(q_a.size()), 32'h0);
    check("final_q_b_empty", 32'(q_b.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
